// File: rtl/ball_bounce_engine.sv
// Ball position/direction engine: advances a ball once per frame tick,
// reflecting and clamping on all four screen edges with per-edge hit pulses.
module ball_bounce_engine #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned STEP_X    = 2,
  parameter int unsigned STEP_Y    = 1,
  parameter int unsigned INIT_X    = 0,
  parameter int unsigned INIT_Y    = 0,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_FrameTick,
  input  logic             i_Enable,
  output logic [POS_W-1:0] o_BallX,
  output logic [POS_W-1:0] o_BallY,
  output logic             o_XDir,
  output logic             o_YDir,
  output logic             o_HitLeft,
  output logic             o_HitRight,
  output logic             o_HitTop,
  output logic             o_HitBottom,
  output logic [CNT_W-1:0] o_HitCount,
  output logic             o_Busy,
  output logic             o_Overrun
);

  localparam int unsigned X_MAX = H_ACTIVE - BALL_SIZE;
  localparam int unsigned Y_MAX = V_ACTIVE - BALL_SIZE;

  // One extra bit so position + step can never wrap before the limit compare
  localparam logic [POS_W:0] X_MAX_E  = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0] Y_MAX_E  = (POS_W+1)'(Y_MAX);
  localparam logic [POS_W:0] STEP_X_E = (POS_W+1)'(STEP_X);
  localparam logic [POS_W:0] STEP_Y_E = (POS_W+1)'(STEP_Y);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] x_d, y_d;
  logic             xdir_d, ydir_d;
  logic             lat_left_q, lat_left_d;
  logic             lat_right_q, lat_right_d;
  logic             hit_left_d, hit_right_d, hit_top_d, hit_bottom_d;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_d, overrun_d;

  logic [POS_W:0]   x_sum, y_sum;
  logic [1:0]       n_hits;
  logic [CNT_W:0]   cnt_sum;

  // Next-state, next-position and hit bookkeeping
  always_comb begin
    state_d      = state_q;
    x_d          = o_BallX;
    y_d          = o_BallY;
    xdir_d       = o_XDir;
    ydir_d       = o_YDir;
    lat_left_d   = lat_left_q;
    lat_right_d  = lat_right_q;
    hit_left_d   = 1'b0;
    hit_right_d  = 1'b0;
    hit_top_d    = 1'b0;
    hit_bottom_d = 1'b0;
    cnt_d        = o_HitCount;
    overrun_d    = o_Overrun | (i_FrameTick & (state_q != IDLE));
    x_sum        = {1'b0, o_BallX} + STEP_X_E;
    y_sum        = {1'b0, o_BallY} + STEP_Y_E;
    n_hits       = 2'd0;
    cnt_sum      = '0;

    case (state_q)
      IDLE: begin
        if (i_FrameTick && i_Enable) begin
          state_d = MOVE_X;
        end
      end

      MOVE_X: begin
        state_d = MOVE_Y;
        if (o_XDir) begin
          if (x_sum >= X_MAX_E) begin
            x_d         = X_MAX_E[POS_W-1:0];
            xdir_d      = 1'b0;
            lat_right_d = 1'b1;
          end else begin
            x_d = x_sum[POS_W-1:0];
          end
        end else begin
          if ({1'b0, o_BallX} <= STEP_X_E) begin
            x_d        = '0;
            xdir_d     = 1'b1;
            lat_left_d = 1'b1;
          end else begin
            x_d = o_BallX - STEP_X_E[POS_W-1:0];
          end
        end
      end

      // Y step; hit pulses and count are registered here so they show in REPORT
      MOVE_Y: begin
        state_d = REPORT;
        if (o_YDir) begin
          if (y_sum >= Y_MAX_E) begin
            y_d          = Y_MAX_E[POS_W-1:0];
            ydir_d       = 1'b0;
            hit_bottom_d = 1'b1;
          end else begin
            y_d = y_sum[POS_W-1:0];
          end
        end else begin
          if ({1'b0, o_BallY} <= STEP_Y_E) begin
            y_d       = '0;
            ydir_d    = 1'b1;
            hit_top_d = 1'b1;
          end else begin
            y_d = o_BallY - STEP_Y_E[POS_W-1:0];
          end
        end
        hit_left_d  = lat_left_q;
        hit_right_d = lat_right_q;
        n_hits      = 2'(lat_left_q) + 2'(lat_right_q) + 2'(hit_top_d) + 2'(hit_bottom_d);
        cnt_sum     = {1'b0, o_HitCount} + (CNT_W+1)'(n_hits);
        cnt_d       = cnt_sum[CNT_W] ? CNT_SAT : cnt_sum[CNT_W-1:0];
      end

      REPORT: begin
        state_d     = IDLE;
        lat_left_d  = 1'b0;
        lat_right_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      o_BallX     <= POS_W'(INIT_X);
      o_BallY     <= POS_W'(INIT_Y);
      o_XDir      <= 1'b1;
      o_YDir      <= 1'b1;
      lat_left_q  <= 1'b0;
      lat_right_q <= 1'b0;
      o_HitLeft   <= 1'b0;
      o_HitRight  <= 1'b0;
      o_HitTop    <= 1'b0;
      o_HitBottom <= 1'b0;
      o_HitCount  <= '0;
      o_Busy      <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_BallX     <= x_d;
      o_BallY     <= y_d;
      o_XDir      <= xdir_d;
      o_YDir      <= ydir_d;
      lat_left_q  <= lat_left_d;
      lat_right_q <= lat_right_d;
      o_HitLeft   <= hit_left_d;
      o_HitRight  <= hit_right_d;
      o_HitTop    <= hit_top_d;
      o_HitBottom <= hit_bottom_d;
      o_HitCount  <= cnt_d;
      o_Busy      <= busy_d;
      o_Overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_ball_bounce_engine.sv
// Directed bench for ball_bounce_engine: four instances cover default motion,
// right-edge clamp, corner reflections and hit-count saturation.
module tb_ball_bounce_engine;

  logic       clk;
  logic       rst_n;
  logic       tick [4];
  logic       en   [4];
  logic [9:0] bx   [4];
  logic [9:0] by   [4];
  logic       xd   [4];
  logic       yd   [4];
  logic       hl   [4];
  logic       hr   [4];
  logic       ht   [4];
  logic       hb   [4];
  logic       busy [4];
  logic       ovr  [4];
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: all defaults
  ball_bounce_engine u_def (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_FrameTick(tick[0]), .i_Enable(en[0]),
    .o_BallX(bx[0]), .o_BallY(by[0]), .o_XDir(xd[0]), .o_YDir(yd[0]),
    .o_HitLeft(hl[0]), .o_HitRight(hr[0]), .o_HitTop(ht[0]), .o_HitBottom(hb[0]),
    .o_HitCount(cnt0), .o_Busy(busy[0]), .o_Overrun(ovr[0]));

  // Instance 1: starts two pixels short of the right limit
  ball_bounce_engine #(.INIT_X(630)) u_right (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_FrameTick(tick[1]), .i_Enable(en[1]),
    .o_BallX(bx[1]), .o_BallY(by[1]), .o_XDir(xd[1]), .o_YDir(yd[1]),
    .o_HitLeft(hl[1]), .o_HitRight(hr[1]), .o_HitTop(ht[1]), .o_HitBottom(hb[1]),
    .o_HitCount(cnt1), .o_Busy(busy[1]), .o_Overrun(ovr[1]));

  // Instance 2: 16x16 screen, limits 8/8, unit steps, corner approach
  ball_bounce_engine #(.H_ACTIVE(16), .V_ACTIVE(16), .STEP_X(1), .STEP_Y(1),
                       .INIT_X(7), .INIT_Y(7)) u_corner (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_FrameTick(tick[2]), .i_Enable(en[2]),
    .o_BallX(bx[2]), .o_BallY(by[2]), .o_XDir(xd[2]), .o_YDir(yd[2]),
    .o_HitLeft(hl[2]), .o_HitRight(hr[2]), .o_HitTop(ht[2]), .o_HitBottom(hb[2]),
    .o_HitCount(cnt2), .o_Busy(busy[2]), .o_Overrun(ovr[2]));

  // Instance 3: 10x10 screen, limits 2/2, 2-bit counter
  ball_bounce_engine #(.H_ACTIVE(10), .V_ACTIVE(10), .STEP_X(1), .STEP_Y(1),
                       .CNT_W(2)) u_sat (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_FrameTick(tick[3]), .i_Enable(en[3]),
    .o_BallX(bx[3]), .o_BallY(by[3]), .o_XDir(xd[3]), .o_YDir(yd[3]),
    .o_HitLeft(hl[3]), .o_HitRight(hr[3]), .o_HitTop(ht[3]), .o_HitBottom(hb[3]),
    .o_HitCount(cnt3), .o_Busy(busy[3]), .o_Overrun(ovr[3]));

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hit pulses packed as {left, right, top, bottom}
  function automatic logic [31:0] hits(input int i);
    return {28'd0, hl[i], hr[i], ht[i], hb[i]};
  endfunction

  // One-cycle tick on instance i; returns at the negedge inside REPORT
  task automatic pulse_tick(input int i);
    @(negedge clk);
    tick[i] = 1'b1;
    @(negedge clk);
    tick[i] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick[i] = 1'b0;
      en[i]   = 1'b1;
    end
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_x",     32'(bx[0]), 0);
    check("rst_y",     32'(by[0]), 0);
    check("rst_xdir",  32'(xd[0]), 1);
    check("rst_ydir",  32'(yd[0]), 1);
    check("rst_cnt",   32'(cnt0), 0);
    check("rst_busy",  32'(busy[0]), 0);
    check("rst_hits",  hits(0), 0);
    check("rst_ovr",   32'(ovr[0]), 0);
    check("rst_initx", 32'(bx[1]), 630);

    // First tick: busy window and staggered X/Y update
    @(negedge clk);
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    check("t1_busy1", 32'(busy[0]), 1);
    check("t1_x_old", 32'(bx[0]), 0);
    @(negedge clk);
    check("t1_busy2", 32'(busy[0]), 1);
    check("t1_x_new", 32'(bx[0]), 2);
    check("t1_y_old", 32'(by[0]), 0);
    @(negedge clk);
    check("t1_busy3", 32'(busy[0]), 1);
    check("t1_y_new", 32'(by[0]), 1);
    @(negedge clk);
    check("t1_idle",  32'(busy[0]), 0);

    // Four more ticks
    repeat (4) begin
      pulse_tick(0);
      @(negedge clk);
    end
    check("t5_x",   32'(bx[0]), 10);
    check("t5_y",   32'(by[0]), 5);
    check("t5_cnt", 32'(cnt0), 0);

    // Disabled: ticks ignored, not an overrun
    en[0] = 1'b0;
    repeat (3) begin
      pulse_tick(0);
      check("dis_busy", 32'(busy[0]), 0);
    end
    @(negedge clk);
    check("dis_x",   32'(bx[0]), 10);
    check("dis_y",   32'(by[0]), 5);
    check("dis_ovr", 32'(ovr[0]), 0);
    en[0] = 1'b1;

    // Back-to-back ticks: second ignored and flagged
    @(negedge clk);
    tick[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("ovr_x",   32'(bx[0]), 12);
    check("ovr_y",   32'(by[0]), 6);
    check("ovr_set", 32'(ovr[0]), 1);
    repeat (10) @(negedge clk);
    check("ovr_sticky", 32'(ovr[0]), 1);
    check("ovr_x_hold", 32'(bx[0]), 12);

    // Right edge: 630+2 lands on 632
    pulse_tick(1);
    check("rt_hits", hits(1), 32'b0100);
    check("rt_x",    32'(bx[1]), 632);
    check("rt_xdir", 32'(xd[1]), 0);
    check("rt_cnt",  32'(cnt1), 1);
    @(negedge clk);
    check("rt_pulse_end", hits(1), 0);
    pulse_tick(1);
    @(negedge clk);
    check("rt_back_x", 32'(bx[1]), 630);
    check("rt_cnt2",   32'(cnt1), 1);

    // Corner: right/bottom first, then walk back to 1,1 and hit left/top
    pulse_tick(2);
    check("cb_hits", hits(2), 32'b0101);
    check("cb_cnt",  32'(cnt2), 2);
    check("cb_x",    32'(bx[2]), 8);
    check("cb_y",    32'(by[2]), 8);
    @(negedge clk);
    check("cb_dirs", {30'd0, xd[2], yd[2]}, 0);
    repeat (7) begin
      pulse_tick(2);
      @(negedge clk);
    end
    check("ct_pre_x", 32'(bx[2]), 1);
    check("ct_pre_y", 32'(by[2]), 1);
    pulse_tick(2);
    check("ct_hits", hits(2), 32'b1010);
    check("ct_cnt",  32'(cnt2), 4);
    check("ct_x",    32'(bx[2]), 0);
    check("ct_y",    32'(by[2]), 0);
    @(negedge clk);
    check("ct_dirs", {30'd0, xd[2], yd[2]}, 3);

    // Saturating 2-bit hit counter
    pulse_tick(3);
    @(negedge clk);
    pulse_tick(3);
    check("sat_cnt2", 32'(cnt3), 2);
    @(negedge clk);
    pulse_tick(3);
    @(negedge clk);
    pulse_tick(3);
    check("sat_hits", hits(3), 32'b1010);
    check("sat_cnt3", 32'(cnt3), 3);
    @(negedge clk);
    pulse_tick(3);
    @(negedge clk);
    pulse_tick(3);
    check("sat_hold", 32'(cnt3), 3);
    check("sat_x",    32'(bx[3]), 2);
    @(negedge clk);

    // Async reset while instance 0 is in MOVE_Y
    @(negedge clk);
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    @(negedge clk);
    check("ar_pre_x", 32'(bx[0]), 14);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_x",    32'(bx[0]), 0);
    check("ar_y",    32'(by[0]), 0);
    check("ar_xdir", 32'(xd[0]), 1);
    check("ar_busy", 32'(busy[0]), 0);
    check("ar_ovr",  32'(ovr[0]), 0);
    check("ar_cnt",  32'(cnt2), 0);
    check("ar_x1",   32'(bx[1]), 630);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
